// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter over per-source ALU/MUL result FIFOs.
// Define CDB_BYPASS_EN to let an empty source's input go straight onto the CDB.
module cdb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int REG_W  = 5,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_ALU,
  input  logic [REG_W-1:0]  dst_ALU,
  input  logic [TAG_W-1:0]  tag_ALU,
  input  logic [DATA_W-1:0] data_ALU,
  input  logic              we_MUL,
  input  logic [REG_W-1:0]  dst_MUL,
  input  logic [TAG_W-1:0]  tag_MUL,
  input  logic [DATA_W-1:0] data_MUL,
  output logic              cdb_we,
  output logic [REG_W-1:0]  cdb_dst,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              stall_ALU,
  output logic              stall_MUL,
  output logic              ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = REG_W + TAG_W + DATA_W;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MUL = 1'b1} src_e;

  logic [EW-1:0] mem_q [2][DEPTH];
  logic [PW-1:0] rd_q [2];
  logic [PW-1:0] rd_d [2];
  logic [PW-1:0] wr_q [2];
  logic [PW-1:0] wr_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [EW-1:0] in_ent [2];
  src_e          last_q, last_d, gnt_src;
  logic          ovf_q, ovf_d;
  logic          cdb_we_q, cdb_we_d;
  logic [EW-1:0] cdb_ent_q, cdb_ent_d;
  logic [1:0]    in_we, empty, cand, granted, pop, push, drop;
  logic          gnt_any, gsel;

  assign in_we     = {we_MUL, we_ALU};
  assign in_ent[0] = {dst_ALU, tag_ALU, data_ALU};
  assign in_ent[1] = {dst_MUL, tag_MUL, data_MUL};

  always_comb begin
    gnt_src   = SRC_ALU;
    gsel      = 1'b0;
    empty     = '0;
    cand      = '0;
    granted   = '0;
    pop       = '0;
    push      = '0;
    drop      = '0;
    cdb_ent_d = cdb_ent_q;
    for (int s = 0; s < 2; s++) begin
      empty[s] = (cnt_q[s] == '0);
`ifdef CDB_BYPASS_EN
      cand[s]  = !empty[s] || in_we[s];
`else
      cand[s]  = !empty[s];
`endif
    end
    gnt_any = |cand;
    // On a tie the source that did not win last time goes first.
    if (&cand)        gnt_src = (last_q == SRC_MUL) ? SRC_ALU : SRC_MUL;
    else if (cand[1]) gnt_src = SRC_MUL;
    else              gnt_src = SRC_ALU;
    gsel = (gnt_src == SRC_MUL);
    for (int s = 0; s < 2; s++) begin
      granted[s] = gnt_any && (gsel == 1'(s));
      pop[s]     = granted[s] && !empty[s];
      // A granted empty source is a bypass: its input never enters the FIFO.
      push[s]    = in_we[s] && !(granted[s] && empty[s]) &&
                   ((cnt_q[s] != CW'(DEPTH)) || pop[s]);
      drop[s]    = in_we[s] && !(granted[s] && empty[s]) && !push[s];
      cnt_d[s]   = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      rd_d[s]    = rd_q[s] + PW'(pop[s]);
      wr_d[s]    = wr_q[s] + PW'(push[s]);
    end
    if (gnt_any) cdb_ent_d = empty[gsel] ? in_ent[gsel] : mem_q[gsel][rd_q[gsel]];
    cdb_we_d = gnt_any;
    last_d   = gnt_any ? gnt_src : last_q;
    ovf_d    = ovf_q || (|drop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        rd_q[s]  <= '0;
        wr_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
      last_q    <= SRC_MUL;
      ovf_q     <= 1'b0;
      cdb_we_q  <= 1'b0;
      cdb_ent_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        rd_q[s]  <= rd_d[s];
        wr_q[s]  <= wr_d[s];
        cnt_q[s] <= cnt_d[s];
      end
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      cdb_we_q  <= cdb_we_d;
      cdb_ent_q <= cdb_ent_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wr_q[s]] <= in_ent[s];
    end
  end

  assign cdb_we                       = cdb_we_q;
  assign {cdb_dst, cdb_tag, cdb_data} = cdb_ent_q;
  // Leaves one slot for the result already sitting in the source register.
  assign stall_ALU = (cnt_q[0] >= CW'(DEPTH - 1));
  assign stall_MUL = (cnt_q[1] >= CW'(DEPTH - 1));
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter.
// Expected entries are queued per source at stimulus time; a monitor pops them on cdb_we.
module tb_cdb_arbiter;
`ifdef CDB_BYPASS_EN
  localparam int LAT   = 1;
  localparam int OVF_N = 9;
`else
  localparam int LAT   = 2;
  localparam int OVF_N = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we_ALU = 1'b0, we_MUL = 1'b0;
  logic [4:0]  dst_ALU = '0, tag_ALU = '0, dst_MUL = '0, tag_MUL = '0;
  logic [31:0] data_ALU = '0, data_MUL = '0;
  logic        cdb_we, stall_ALU, stall_MUL, ovf;
  logic [4:0]  cdb_dst, cdb_tag;
  logic [31:0] cdb_data;

  int n_chk = 0;
  int n_pass = 0;
  logic [41:0] exp_alu[$];
  logic [41:0] exp_mul[$];
  logic [4:0]  seen[$];
  logic        saw_stall_alu, saw_stall_mul;
  logic [41:0] e;

  cdb_arbiter #(.DEPTH(4), .REG_W(5), .TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .we_ALU(we_ALU), .dst_ALU(dst_ALU), .tag_ALU(tag_ALU), .data_ALU(data_ALU),
    .we_MUL(we_MUL), .dst_MUL(dst_MUL), .tag_MUL(tag_MUL), .data_MUL(data_MUL),
    .cdb_we(cdb_we), .cdb_dst(cdb_dst), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .stall_ALU(stall_ALU), .stall_MUL(stall_MUL), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ALU entries use dst 0..15, MUL entries dst 16..31, so dst[4] names the source.
  function automatic logic [41:0] ent(input logic m, input logic [4:0] t);
    ent = {m, t[3:0], t, (m ? 32'h5A00_0000 : 32'hA500_0000) | {27'd0, t}};
  endfunction

  task automatic drive(input logic aw, input logic [4:0] at, input logic ae,
                       input logic mw, input logic [4:0] mt, input logic me);
    {dst_ALU, tag_ALU, data_ALU} = ent(1'b0, at);
    {dst_MUL, tag_MUL, data_MUL} = ent(1'b1, mt);
    we_ALU = aw;
    we_MUL = mw;
    if (aw && ae) exp_alu.push_back(ent(1'b0, at));
    if (mw && me) exp_mul.push_back(ent(1'b1, mt));
  endtask

  task automatic step(input logic aw, input logic [4:0] at, input logic ae,
                      input logic mw, input logic [4:0] mt, input logic me);
    @(negedge clk);
    drive(aw, at, ae, mw, mt, me);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    exp_alu.delete();
    exp_mul.delete();
    @(negedge clk);
    rst = 1'b0;
    seen.delete();
  endtask

  task automatic drain(input string nm);
    idle();
    for (int k = 0; k < 40 && (exp_alu.size() + exp_mul.size()) != 0; k++) @(negedge clk);
    @(negedge clk);
    chk(nm, 64'(exp_alu.size() + exp_mul.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && cdb_we) begin
      seen.push_back(cdb_tag);
      if (cdb_dst[4] ? (exp_mul.size() == 0) : (exp_alu.size() == 0)) begin
        n_chk++;
        $display("FAIL spurious_cdb: got dst=%0h tag=%0h data=%0h expected no broadcast",
                 cdb_dst, cdb_tag, cdb_data);
      end else if (cdb_dst[4]) begin
        chk("cdb_mul_entry", 64'({cdb_dst, cdb_tag, cdb_data}), 64'(exp_mul.pop_front()));
      end else begin
        chk("cdb_alu_entry", 64'({cdb_dst, cdb_tag, cdb_data}), 64'(exp_alu.pop_front()));
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_cdb_we", 64'(cdb_we), 64'd0);
    chk("rst_cdb_fields", 64'({cdb_dst, cdb_tag, cdb_data}), 64'd0);
    chk("rst_stalls", 64'({stall_ALU, stall_MUL}), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single ALU result and its latency.
    @(negedge clk);
    we_ALU = 1'b1; dst_ALU = 5'd3; tag_ALU = 5'd7; data_ALU = 32'hDEADBEEF;
    exp_alu.push_back({5'd3, 5'd7, 32'hDEADBEEF});
    @(negedge clk);
    chk("lat_edge1_we", 64'(cdb_we), 64'(LAT == 1));
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("lat_edge2_we", 64'(cdb_we), 64'(LAT == 2));
    @(negedge clk);
    chk("lat_after_we", 64'(cdb_we), 64'd0);
    drain("single_drain");

    // Simultaneous pairs right after reset: ALU wins the first tie, then alternation.
    do_reset();
    idle();
    step(1'b1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1);
    step(1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1);
    for (int k = 0; k < 6; k++) idle();
    chk("pair_count", 64'(seen.size()), 64'd4);
    for (int k = 0; k < 4 && k < seen.size(); k++) chk("pair_order", 64'(seen[k]), 64'(k + 1));
    drain("pair_drain");

    // Back-pressure honoured by issue: stalls appear, nothing is dropped.
    do_reset();
    saw_stall_alu = 1'b0;
    saw_stall_mul = 1'b0;
    begin
      logic [4:0] ta, tm;
      logic       aw, mw;
      ta = '0; tm = '0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        saw_stall_alu = saw_stall_alu | stall_ALU;
        saw_stall_mul = saw_stall_mul | stall_MUL;
        aw = !stall_ALU;
        mw = !stall_MUL;
        drive(aw, ta, 1'b1, mw, tm, 1'b1);
        ta = ta + 5'(aw);
        tm = tm + 5'(mw);
      end
    end
    drain("bp_drain");
    chk("bp_stall_mul_seen", 64'(saw_stall_mul), 64'd1);
    chk("bp_stall_alu_seen", 64'(saw_stall_alu), 64'd1);
    chk("bp_no_ovf", 64'(ovf), 64'd0);
    chk("bp_stalls_clear", 64'({stall_ALU, stall_MUL}), 64'd0);

    // Overflow: both push every cycle ignoring stall; the last MUL push is dropped.
    do_reset();
    for (int k = 0; k < OVF_N - 1; k++) step(1'b1, 5'(k), 1'b1, 1'b1, 5'(k), 1'b1);
    @(negedge clk);
    chk("ovf_before_drop", 64'(ovf), 64'd0);
    chk("ovf_mul_full_stall", 64'(stall_MUL), 64'd1);
    drive(1'b1, 5'(OVF_N - 1), 1'b1, 1'b1, 5'(OVF_N - 1), 1'b0);
    @(negedge clk);
    chk("ovf_set", 64'(ovf), 64'd1);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    drain("ovf_drain");
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Asynchronous reset mid-cycle with three entries buffered.
    idle();
    step(1'b1, 5'd10, 1'b1, 1'b1, 5'd10, 1'b1);
    step(1'b1, 5'd11, 1'b1, 1'b1, 5'd11, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_alu.delete();
    exp_mul.delete();
    #1;
    chk("arst_cdb_we", 64'(cdb_we), 64'd0);
    chk("arst_cdb_fields", 64'({cdb_dst, cdb_tag, cdb_data}), 64'd0);
    chk("arst_stalls", 64'({stall_ALU, stall_MUL}), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("arst_no_broadcast", 64'(cdb_we), 64'd0);
    end
    step(1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b1);
    drain("arst_new_push");

    // Wrap-around: ten ALU pushes with gaps.
    seen.delete();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 5'(k), 1'b1, 1'b0, 5'd0, 1'b0);
      idle();
      idle();
    end
    drain("wrap_drain");
    chk("wrap_count", 64'(seen.size()), 64'd10);
    for (int k = 0; k < 10 && k < seen.size(); k++) chk("wrap_order", 64'(seen[k]), 64'(k));
    chk("wrap_stall_alu", 64'(stall_ALU), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
